router_dest_reader: RTL and testbench

- Destination-side consumer for one router output FIFO; drains one packet at a time. Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte equal to the XOR of the header and all payload bytes.
- Drives read_enb from FIFO not-empty and captures bytes with 1-cycle read latency.
- Outputs the payload as a byte stream and checks parity and address.
- Keeps packet and error counters for the bench and system monitor.

---
 rtl/router_dest_reader.sv | 206 ++++++++++++++++++++
 tb/tb_router_dest_reader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_dest_reader.sv
// router_dest_reader: destination-side consumer for one router output FIFO.
// Drains one packet at a time ({len,addr} header, len payload bytes, XOR
// parity byte), streams the payload out, checks parity and address, and keeps
// packet/error counters. The FIFO has a one-cycle read latency, so every read
// strobe is tracked by rd_pend_q and the byte is captured on the following edge.
module router_dest_reader #(
    parameter logic [1:0] ADDR       = 2'b00,
    parameter int         READ_DELAY = 0,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_out,
    input  logic [7:0]       data_out,
    input  logic             soft_reset,
    output logic             read_enb,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic [5:0]       pkt_len,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last value of the wait counter before moving on to READ.
    localparam logic [4:0] WAIT_LAST = 5'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);

    state_t           state_q, state_d;
    logic [4:0]       wait_q, wait_d;

    logic [6:0]       issued_q;      // reads issued for the current packet
    logic [6:0]       recv_q;        // bytes captured for the current packet
    logic             hdr_seen_q;    // header captured, len_q is valid
    logic             rd_pend_q;     // a read was issued last cycle
    logic [5:0]       len_q;
    logic [1:0]       addr_q;
    logic [7:0]       acc_q;         // running XOR of header and payload

    logic             byte_valid_q;
    logic [7:0]       byte_data_q;
    logic             done_q;
    logic             perr_q;
    logic             aerr_q;
    logic             abort_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [6:0]       len_ext;
    logic [6:0]       limit;
    logic             kill;
    logic             capture;
    logic             last_capture;
    logic             rd_en;

    // Until the header arrives only two reads are allowed: the header itself and
    // a speculative second read, which is safe because every packet carries at
    // least a parity byte after the header.
    assign len_ext      = {1'b0, len_q};
    assign limit        = hdr_seen_q ? (len_ext + 7'd2) : 7'd2;
    // Soft reset only matters while a packet is being fetched; DONE has already
    // consumed the whole packet, so it completes normally.
    assign kill         = soft_reset && ((state_q == S_WAIT) || (state_q == S_READ));
    assign capture      = (state_q == S_READ) && rd_pend_q;
    // recv_q is never 0 when this matches, so a stale len_q during the header
    // capture cannot trigger it.
    assign last_capture = capture && (recv_q == (len_ext + 7'd1));
    assign rd_en        = (state_q == S_READ) && valid_out && !soft_reset && (issued_q < limit);

    assign read_enb   = rd_en;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign pkt_len    = len_q;
    assign pkt_done   = done_q;
    assign parity_err = perr_q;
    assign addr_err   = aerr_q;
    assign abort      = abort_q;
    assign busy       = (state_q != S_IDLE);
    assign pkt_cnt    = pkt_cnt_q;
    assign err_cnt    = err_cnt_q;

    // State register and pre-read wait counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> READ -> DONE -> IDLE, soft reset aborts.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (valid_out) begin
                    state_d = (READ_DELAY == 0) ? S_READ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (soft_reset || !valid_out) begin
                    state_d = S_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_READ;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            S_READ: begin
                if (soft_reset) begin
                    state_d = S_IDLE;
                end else if (last_capture) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read tracking, byte capture, parity/address check, pulses and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issued_q     <= '0;
            recv_q       <= '0;
            hdr_seen_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            acc_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            aerr_q       <= 1'b0;
            abort_q      <= 1'b0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            aerr_q       <= 1'b0;
            abort_q      <= 1'b0;
            if (kill) begin
                // Drop the packet, including any byte still in flight.
                abort_q    <= 1'b1;
                err_cnt_q  <= err_cnt_q + CNT_W'(1);
                issued_q   <= '0;
                recv_q     <= '0;
                hdr_seen_q <= 1'b0;
                rd_pend_q  <= 1'b0;
            end else begin
                rd_pend_q <= rd_en;
                if (rd_en) begin
                    issued_q <= issued_q + 7'd1;
                end
                if (capture) begin
                    recv_q <= recv_q + 7'd1;
                    if (recv_q == 7'd0) begin
                        len_q      <= data_out[7:2];
                        addr_q     <= data_out[1:0];
                        acc_q      <= data_out;
                        hdr_seen_q <= 1'b1;
                    end else if (recv_q <= len_ext) begin
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= data_out;
                        acc_q        <= acc_q ^ data_out;
                    end else begin
                        done_q <= 1'b1;
                        perr_q <= (acc_q != data_out);
                        aerr_q <= (addr_q != ADDR);
                    end
                end
                if (state_q == S_DONE) begin
                    pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                    if (perr_q || aerr_q) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                    issued_q   <= '0;
                    recv_q     <= '0;
                    hdr_seen_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_dest_reader.sv
// tb_router_dest_reader: two readers (READ_DELAY 0 and 4, ADDR 01) each fed by
// a FIFO model with one-cycle read latency. A packet-level reference model
// records, for every packet pushed, the payload bytes and the expected
// len/parity/address verdict; a monitor matches the DUT's byte stream and
// pkt_done results against it.
module tb_router_dest_reader;

    localparam int CNT_W = 16;
    localparam logic [1:0] MY_ADDR = 2'b01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn       [2];
    logic             valid_out  [2];
    logic [7:0]       data_out   [2] = '{8'h00, 8'h00};
    logic             soft_reset [2];
    logic             read_enb   [2];
    logic             byte_valid [2];
    logic [7:0]       byte_data  [2];
    logic [5:0]       pkt_len    [2];
    logic             pkt_done   [2];
    logic             parity_err [2];
    logic             addr_err   [2];
    logic             abort_w    [2];
    logic             busy       [2];
    logic [CNT_W-1:0] pkt_cnt    [2];
    logic [CNT_W-1:0] err_cnt    [2];

    router_dest_reader #(.ADDR(MY_ADDR), .READ_DELAY(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .resetn(rstn[0]), .valid_out(valid_out[0]), .data_out(data_out[0]),
        .soft_reset(soft_reset[0]), .read_enb(read_enb[0]), .byte_valid(byte_valid[0]),
        .byte_data(byte_data[0]), .pkt_len(pkt_len[0]), .pkt_done(pkt_done[0]),
        .parity_err(parity_err[0]), .addr_err(addr_err[0]), .abort(abort_w[0]),
        .busy(busy[0]), .pkt_cnt(pkt_cnt[0]), .err_cnt(err_cnt[0])
    );

    router_dest_reader #(.ADDR(MY_ADDR), .READ_DELAY(4), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .resetn(rstn[1]), .valid_out(valid_out[1]), .data_out(data_out[1]),
        .soft_reset(soft_reset[1]), .read_enb(read_enb[1]), .byte_valid(byte_valid[1]),
        .byte_data(byte_data[1]), .pkt_len(pkt_len[1]), .pkt_done(pkt_done[1]),
        .parity_err(parity_err[1]), .addr_err(addr_err[1]), .abort(abort_w[1]),
        .busy(busy[1]), .pkt_cnt(pkt_cnt[1]), .err_cnt(err_cnt[1])
    );

    // FIFO model storage
    logic [7:0] fmem [2][256];
    int         wr_ptr [2] = '{0, 0};
    int         rd_ptr [2] = '{0, 0};
    logic       hold   [2];

    // Reference model: expected payload bytes and per-packet verdicts
    logic [7:0] exp_b   [2][512];
    int         exp_wr  [2] = '{0, 0};
    int         exp_rd  [2] = '{0, 0};
    logic [5:0] d_len   [2][64];
    logic       d_perr  [2][64];
    logic       d_aerr  [2][64];
    int         d_bend  [2][64];
    int         done_wr [2] = '{0, 0};
    int         done_rd [2] = '{0, 0};
    int         mdl_pkt [2] = '{0, 0};
    int         mdl_err [2] = '{0, 0};
    int         seen_bytes [2] = '{0, 0};

    logic [7:0] pl [64];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    assign valid_out[0] = (wr_ptr[0] != rd_ptr[0]) && !hold[0];
    assign valid_out[1] = (wr_ptr[1] != rd_ptr[1]) && !hold[1];

    // FIFO pop with one-cycle read latency; reset and soft reset flush it.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rstn[g] || soft_reset[g]) begin
                rd_ptr[g] <= wr_ptr[g];
            end else if (read_enb[g]) begin
                data_out[g] <= fmem[g][rd_ptr[g] % 256];
                rd_ptr[g]   <= rd_ptr[g] + 1;
            end
        end
    end

    // Monitor: byte stream and packet verdicts against the reference model.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rstn[g]) begin
                mdl_pkt[g] = 0;
                mdl_err[g] = 0;
                exp_rd[g]  = exp_wr[g];
                done_rd[g] = done_wr[g];
            end else begin
                if (abort_w[g]) begin
                    mdl_err[g] = mdl_err[g] + 1;
                    exp_rd[g]  = exp_wr[g];
                    done_rd[g] = done_wr[g];
                end
                if (byte_valid[g]) begin
                    seen_bytes[g] = seen_bytes[g] + 1;
                    if (exp_rd[g] == exp_wr[g]) begin
                        check_eq("unexpected_byte", 32'(byte_data[g]), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("byte_data", 32'(byte_data[g]), 32'(exp_b[g][exp_rd[g] % 512]));
                        exp_rd[g] = exp_rd[g] + 1;
                    end
                end
                if (pkt_done[g]) begin
                    if (done_rd[g] == done_wr[g]) begin
                        check_eq("unexpected_done", 32'(pkt_done[g]), 32'd0);
                    end else begin
                        check_eq("done_len", 32'(pkt_len[g]), 32'(d_len[g][done_rd[g] % 64]));
                        check_eq("done_perr", 32'(parity_err[g]), 32'(d_perr[g][done_rd[g] % 64]));
                        check_eq("done_aerr", 32'(addr_err[g]), 32'(d_aerr[g][done_rd[g] % 64]));
                        check_eq("done_all_bytes", 32'(exp_rd[g]), 32'(d_bend[g][done_rd[g] % 64]));
                        mdl_pkt[g] = mdl_pkt[g] + 1;
                        if (d_perr[g][done_rd[g] % 64] || d_aerr[g][done_rd[g] % 64]) begin
                            mdl_err[g] = mdl_err[g] + 1;
                        end
                        done_rd[g] = done_rd[g] + 1;
                    end
                end
            end
        end
    end

    // Queue one packet (payload from pl[]) and record what it must produce.
    task automatic push_pkt(input int g, input int len, input logic [1:0] adr, input bit bad);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = {len[5:0], adr};
        par = hdr;
        for (int i = 0; i < len; i++) begin
            par = par ^ pl[i];
            exp_b[g][exp_wr[g] % 512] = pl[i];
            exp_wr[g] = exp_wr[g] + 1;
        end
        if (bad) par = par ^ 8'h01;
        d_len[g][done_wr[g] % 64]  = len[5:0];
        d_perr[g][done_wr[g] % 64] = bad;
        d_aerr[g][done_wr[g] % 64] = (adr != MY_ADDR);
        d_bend[g][done_wr[g] % 64] = exp_wr[g];
        done_wr[g] = done_wr[g] + 1;
        fmem[g][wr_ptr[g] % 256] = hdr;
        wr_ptr[g] = wr_ptr[g] + 1;
        for (int i = 0; i < len; i++) begin
            fmem[g][wr_ptr[g] % 256] = pl[i];
            wr_ptr[g] = wr_ptr[g] + 1;
        end
        fmem[g][wr_ptr[g] % 256] = par;
        wr_ptr[g] = wr_ptr[g] + 1;
    endtask

    task automatic rand_payload(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    // Run until the FIFO is empty and the reader idle for a few cycles.
    task automatic wait_idle(input int g, input bit rnd);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            hold[g] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (wr_ptr[g] == rd_ptr[g] && !busy[g]) quiet++;
            else quiet = 0;
            n++;
        end
        hold[g] = 1'b0;
        check_eq("idle_reached", 32'(quiet), 32'd4);
        check_eq("stream_drained", 32'(exp_rd[g]), 32'(exp_wr[g]));
    endtask

    // Cycle positions (relative to the push) of reads, bytes and pkt_done.
    task automatic measure(input int g, output int first, output int nrd, output int last,
                           output int done_c, output int fb, output int lb, output int nb);
        first = -1; nrd = 0; last = -1; done_c = -1; fb = -1; lb = -1; nb = 0;
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (read_enb[g]) begin
                if (first < 0) first = c;
                last = c;
                nrd++;
            end
            if (byte_valid[g]) begin
                if (fb < 0) fb = c;
                lb = c;
                nb++;
            end
            if (pkt_done[g]) done_c = c;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, nrd, last, dc, fb, lb, nb;
        int base, n;
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        soft_reset[0] = 1'b0; soft_reset[1] = 1'b0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_read_enb", 32'(read_enb[0]), 32'd0);
        check_eq("rst_pkt_cnt", 32'(pkt_cnt[0]), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt[0]), 32'd0);
        check_eq("rst_pkt_len", 32'(pkt_len[0]), 32'd0);
        check_eq("rst_byte_valid", 32'(byte_valid[1]), 32'd0);
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal 0D A1 B2 C3 DD
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
        push_pkt(0, 3, MY_ADDR, 1'b0);
        measure(0, first, nrd, last, dc, fb, lb, nb);
        check_eq("nom_first_rd", 32'(first), 32'd1);
        check_eq("nom_num_rd", 32'(nrd), 32'd5);
        check_eq("nom_rd_span", 32'(last - first + 1), 32'd5);
        check_eq("nom_done_lat", 32'(dc - last), 32'd2);
        check_eq("nom_byte_lat", 32'(fb - first), 32'd3);
        check_eq("nom_num_bytes", 32'(nb), 32'd3);
        check_eq("nom_byte_span", 32'(lb - fb), 32'd2);
        wait_idle(0, 1'b0);
        check_eq("nom_pkt_len", 32'(pkt_len[0]), 32'd3);
        check_eq("nom_pkt_cnt", 32'(pkt_cnt[0]), 32'd1);
        check_eq("nom_err_cnt", 32'(err_cnt[0]), 32'd0);

        // Parity byte DC instead of DD
        push_pkt(0, 3, MY_ADDR, 1'b1);
        wait_idle(0, 1'b0);
        check_eq("par_pkt_cnt", 32'(pkt_cnt[0]), 32'd2);
        check_eq("par_err_cnt", 32'(err_cnt[0]), 32'd1);

        // Header 0E: addr 10, parity DE
        push_pkt(0, 3, 2'b10, 1'b0);
        wait_idle(0, 1'b0);
        check_eq("adr_pkt_cnt", 32'(pkt_cnt[0]), 32'd3);
        check_eq("adr_err_cnt", 32'(err_cnt[0]), 32'd2);

        // Stall for 3 cycles after the 2nd payload read
        rand_payload(6);
        push_pkt(0, 6, MY_ADDR, 1'b0);
        n = 0;
        base = 0;
        while (n < 3 && base < 40) begin
            @(negedge clk);
            if (read_enb[0]) n++;
            base++;
        end
        check_eq("stall_reads_seen", 32'(n), 32'd3);
        @(posedge clk);
        #1 hold[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_rd_low", 32'(read_enb[0]), 32'd0);
            @(posedge clk);
        end
        #1 hold[0] = 1'b0;
        wait_idle(0, 1'b0);
        check_eq("stall_pkt_cnt", 32'(pkt_cnt[0]), 32'd4);
        check_eq("stall_err_cnt", 32'(err_cnt[0]), 32'd2);

        // Soft reset after 5 payload bytes of a len 14 packet
        rand_payload(14);
        base = seen_bytes[0];
        push_pkt(0, 14, MY_ADDR, 1'b0);
        n = 0;
        while ((seen_bytes[0] - base) < 5 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("sr_bytes_before", 32'(seen_bytes[0] - base), 32'd5);
        soft_reset[0] = 1'b1;
        #1 check_eq("sr_rd_gated", 32'(read_enb[0]), 32'd0);
        @(posedge clk);
        #1 soft_reset[0] = 1'b0;
        @(negedge clk);
        check_eq("sr_abort", 32'(abort_w[0]), 32'd1);
        check_eq("sr_busy", 32'(busy[0]), 32'd0);
        check_eq("sr_no_done", 32'(pkt_done[0]), 32'd0);
        wait_idle(0, 1'b0);
        check_eq("sr_total_bytes", 32'(seen_bytes[0] - base), 32'd5);
        check_eq("sr_pkt_cnt", 32'(pkt_cnt[0]), 32'd4);
        check_eq("sr_err_cnt", 32'(err_cnt[0]), 32'd3);
        rand_payload(4);
        push_pkt(0, 4, MY_ADDR, 1'b0);
        wait_idle(0, 1'b0);
        check_eq("post_sr_pkt_cnt", 32'(pkt_cnt[0]), 32'd5);
        check_eq("post_sr_err_cnt", 32'(err_cnt[0]), 32'd3);

        // len = 0 packet: header and parity only
        push_pkt(0, 0, MY_ADDR, 1'b0);
        wait_idle(0, 1'b0);
        check_eq("len0_pkt_cnt", 32'(pkt_cnt[0]), 32'd6);
        check_eq("len0_err_cnt", 32'(err_cnt[0]), 32'd3);

        // Randomized back-to-back packets with random valid_out gaps
        for (int it = 0; it < 15; it++) begin
            int np;
            np = $urandom_range(1, 3);
            for (int k = 0; k < np; k++) begin
                int len;
                len = $urandom_range(0, 20);
                rand_payload(len);
                push_pkt(0, len, ($urandom_range(0, 3) == 0) ? 2'b10 : MY_ADDR,
                         ($urandom_range(0, 3) == 0));
            end
            wait_idle(0, 1'b1);
        end
        check_eq("rnd_pkt_cnt", 32'(pkt_cnt[0]), 32'(mdl_pkt[0]));
        check_eq("rnd_err_cnt", 32'(err_cnt[0]), 32'(mdl_err[0]));

        // READ_DELAY = 4: first read 5 cycles after valid_out is seen
        rand_payload(2);
        push_pkt(1, 2, MY_ADDR, 1'b0);
        measure(1, first, nrd, last, dc, fb, lb, nb);
        check_eq("dly_first_rd", 32'(first), 32'd5);
        check_eq("dly_num_rd", 32'(nrd), 32'd4);
        check_eq("dly_done_lat", 32'(dc - last), 32'd2);
        wait_idle(1, 1'b0);
        check_eq("dly_pkt_cnt", 32'(pkt_cnt[1]), 32'd1);

        // Async reset in the middle of a len 14 packet
        rand_payload(14);
        base = seen_bytes[1];
        push_pkt(1, 14, MY_ADDR, 1'b0);
        n = 0;
        while ((seen_bytes[1] - base) < 3 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("arst_bytes_before", 32'(seen_bytes[1] - base), 32'd3);
        #2 rstn[1] = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy[1]), 32'd0);
        check_eq("arst_read_enb", 32'(read_enb[1]), 32'd0);
        check_eq("arst_byte_valid", 32'(byte_valid[1]), 32'd0);
        check_eq("arst_pkt_len", 32'(pkt_len[1]), 32'd0);
        check_eq("arst_pkt_done", 32'(pkt_done[1]), 32'd0);
        check_eq("arst_abort", 32'(abort_w[1]), 32'd0);
        check_eq("arst_pkt_cnt", 32'(pkt_cnt[1]), 32'd0);
        check_eq("arst_err_cnt", 32'(err_cnt[1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn[1] = 1'b1;
        @(negedge clk);
        rand_payload(14);
        push_pkt(1, 14, MY_ADDR, 1'b0);
        wait_idle(1, 1'b0);
        check_eq("arst_post_len", 32'(pkt_len[1]), 32'd14);
        check_eq("arst_post_pkt_cnt", 32'(pkt_cnt[1]), 32'd1);
        check_eq("arst_post_err_cnt", 32'(err_cnt[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
